// File: rtl/cpu_data_bus_if.sv
// Data-memory port between the CPU datapath and cpu_data_bus, plus the
// output FIFO valid/ready channel toward the external consumer.
interface cpu_data_bus_if;
  logic [15:0] i_m_addr;
  logic [15:0] i_m_wdata;
  logic        i_m_we;
  logic [15:0] o_m_rdata;
  logic [15:0] o_out_data;
  logic        o_out_valid;
  logic        i_out_ready;

  // CPU / consumer side
  modport master (
    output i_m_addr, i_m_wdata, i_m_we, i_out_ready,
    input  o_m_rdata, o_out_data, o_out_valid
  );

  // Memory responder side
  modport slave (
    input  i_m_addr, i_m_wdata, i_m_we, i_out_ready,
    output o_m_rdata, o_out_data, o_out_valid
  );
endinterface

// File: rtl/cpu_data_bus.sv
// Memory-side responder for the CPU data port: data RAM plus an I/O page
// holding a cycle timer, an output FIFO, its status and a drop counter.
module cpu_data_bus #(
  parameter int unsigned RAM_AW     = 12,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  cpu_data_bus_if.slave  bus
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;
  localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW        = PW + 1;

  localparam logic [15:0] ADDR_OUT_DATA = 16'h7FF0;
  localparam logic [15:0] ADDR_STATUS   = 16'h7FF1;
  localparam logic [15:0] ADDR_TIMER    = 16'h7FF2;
  localparam logic [15:0] ADDR_DROPS    = 16'h7FF3;

  logic [15:0]   ram [RAM_WORDS];
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   timer;
  logic [15:0]   drops;

  logic        ram_sel;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        drop;
  logic        timer_wr;
  logic        drops_clr;
  logic [15:0] status;

  // Address decode and FIFO handshake qualifiers, all on pre-edge state
  always_comb begin
    ram_sel    = (bus.i_m_addr[15:RAM_AW] == '0);
    fifo_full  = (count == CW'(FIFO_DEPTH));
    fifo_empty = (count == '0);
    push_req   = bus.i_m_we && (bus.i_m_addr == ADDR_OUT_DATA);
    push       = push_req && !fifo_full;
    drop       = push_req && fifo_full;
    pop        = !fifo_empty && bus.i_out_ready;
    timer_wr   = bus.i_m_we && (bus.i_m_addr == ADDR_TIMER);
    drops_clr  = bus.i_m_we && (bus.i_m_addr == ADDR_DROPS);
    status     = {8'h00, 4'(count), 2'b00, fifo_empty, fifo_full};
  end

  // Zero-latency read mux over RAM and the I/O page
  always_comb begin
    bus.o_m_rdata = 16'h0000;
    if (ram_sel) begin
      bus.o_m_rdata = ram[bus.i_m_addr[RAM_AW-1:0]];
    end else begin
      case (bus.i_m_addr)
        ADDR_STATUS: bus.o_m_rdata = status;
        ADDR_TIMER:  bus.o_m_rdata = timer;
        ADDR_DROPS:  bus.o_m_rdata = drops;
        default:     bus.o_m_rdata = 16'h0000;
      endcase
    end
  end

  // FIFO head presented first-word-fall-through, zero when empty
  always_comb begin
    bus.o_out_valid = !fifo_empty;
    bus.o_out_data  = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr];
  end

  // Data RAM storage; contents intentionally survive reset
  always_ff @(posedge i_clk) begin
    if (bus.i_m_we && ram_sel) begin
      ram[bus.i_m_addr[RAM_AW-1:0]] <= bus.i_m_wdata;
    end
  end

  // FIFO payload storage; only slots between the pointers are meaningful
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.i_m_wdata;
    end
  end

  // FIFO pointers and occupancy; a full FIFO rejects pushes even when popping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Free-running timer; a write loads instead of incrementing
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer <= 16'h0000;
    end else if (timer_wr) begin
      timer <= bus.i_m_wdata;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  // Saturating drop counter; a clear beats a same-edge drop
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      drops <= 16'h0000;
    end else if (drops_clr) begin
      drops <= 16'h0000;
    end else if (drop && (drops != 16'hFFFF)) begin
      drops <= drops + 16'd1;
    end
  end

endmodule
